register_file_arbiter: RTL and testbench

Controller that shares one dual-read, single-write register file between two requesters, and sequences a full-array clear. Each requester uses a valid/ready request channel and a one-cycle-latency read response. The block drives the register file's write enable, write data, address A and address B. It sits between the register file and its two clients (e.g. datapath and debug/host port).

---
 rtl/register_file_arbiter_pkg.sv | 26 ++
 rtl/register_file_arbiter_round_robin.sv | 46 ++++
 rtl/register_file_arbiter.sv | 156 +++++++++++++++
 tb/tb_register_file_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_file_arbiter_pkg
// Brief    : Shared types and constants for the register file arbiter slice.
// Revision : 1.0
// ============================================================================
package register_file_arbiter_pkg;

   localparam int C_NUM_REQ = 2;

   localparam logic [0:0] C_STATE_CLEAR = 1'b0;
   localparam logic [0:0] C_STATE_SERVE = 1'b1;

   typedef enum logic [0:0] {
      CLEAR = C_STATE_CLEAR,
      SERVE = C_STATE_SERVE
   } state_e;

   // Both requesters reading is the only case where two grants can coexist.
   function automatic logic is_dual_read(input logic [C_NUM_REQ-1:0] valid,
                                         input logic [C_NUM_REQ-1:0] write);
      return (&valid) && !(|write);
   endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_arbiter_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter
// Brief    : Two-way round-robin grant with pointer and dual-grant hold.
// Revision : 1.0
// ============================================================================
module round_robin_arbiter
   import register_file_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 hold,
   input  logic [C_NUM_REQ-1:0] request,
   output logic [C_NUM_REQ-1:0] grant
);

   logic                 r_pointer;
   logic [C_NUM_REQ-1:0] w_grant;

   always_comb begin
      w_grant = '0;
      if (enable) begin
         if (hold) begin
            w_grant = request;
         end else if (request[r_pointer]) begin
            w_grant[r_pointer] = 1'b1;
         end else if (request[~r_pointer]) begin
            w_grant[~r_pointer] = 1'b1;
         end
      end
   end

   // After a single grant, priority passes to the requester that was not served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pointer <= 1'b0;
      end else if (enable && !hold && (|w_grant)) begin
         r_pointer <= w_grant[0];
      end
   end

   assign grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/register_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : register_file_arbiter
// Brief    : Shares a 2R/1W register file between two requesters and
//            sequences a full-array clear.
// Revision : 1.0
// ============================================================================
module register_file_arbiter
   import register_file_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 6,
   parameter int REGISTER_WIDTH  = 16,
   parameter int REGISTER_HEIGHT = 1 << ADDRESS_WIDTH
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [C_NUM_REQ-1:0]                     req_valid,
   output logic [C_NUM_REQ-1:0]                     req_ready,
   input  logic [C_NUM_REQ-1:0]                     req_write,
   input  logic [C_NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_address,
   input  logic [C_NUM_REQ-1:0][REGISTER_WIDTH-1:0] req_write_data,
   output logic [C_NUM_REQ-1:0]                     rsp_valid,
   output logic [C_NUM_REQ-1:0][REGISTER_WIDTH-1:0] rsp_data,
   input  logic                                     clear_start,
   output logic                                     busy,
   output logic                                     clear_done,
   output logic                                     rf_write_enable,
   output logic [REGISTER_WIDTH-1:0]                rf_write_data,
   output logic [ADDRESS_WIDTH-1:0]                 rf_address_a,
   output logic [ADDRESS_WIDTH-1:0]                 rf_address_b,
   input  logic [REGISTER_WIDTH-1:0]                rf_read_data_a,
   input  logic [REGISTER_WIDTH-1:0]                rf_read_data_b
);

   localparam logic [ADDRESS_WIDTH-1:0] C_LAST = ADDRESS_WIDTH'(REGISTER_HEIGHT - 1);

   state_e                                r_state;
   logic [ADDRESS_WIDTH-1:0]              r_counter;
   logic                                  r_clear_done;

   logic                                  w_arb_enable;
   logic                                  w_dual_read;
   logic [C_NUM_REQ-1:0]                  w_grant;
   logic                                  w_we;
   logic [REGISTER_WIDTH-1:0]             w_wdata;
   logic [ADDRESS_WIDTH-1:0]              w_addr_a;
   logic [ADDRESS_WIDTH-1:0]              w_addr_b;
   logic [C_NUM_REQ-1:0][REGISTER_WIDTH-1:0] w_port_data;

   // Clear has priority: a pending clear_start blocks grants in the same cycle.
   assign w_arb_enable = (r_state == SERVE) && !clear_start;
   assign w_dual_read  = is_dual_read(req_valid, req_write);

   round_robin_arbiter u_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (w_arb_enable),
      .hold    (w_dual_read),
      .request (req_valid),
      .grant   (w_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= CLEAR;
         r_counter    <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_clear_done <= 1'b0;
         case (r_state)
            CLEAR: begin
               r_counter <= r_counter + 1'b1;
               if (r_counter == C_LAST) begin
                  r_state      <= SERVE;
                  r_counter    <= '0;
                  r_clear_done <= 1'b1;
               end
            end
            SERVE: begin
               r_counter <= '0;
               if (clear_start) begin
                  r_state <= CLEAR;
               end
            end
            default: begin
               r_state   <= CLEAR;
               r_counter <= '0;
            end
         endcase
      end
   end

   // Requester 0 owns port A, requester 1 owns port B; writes always use port A.
   always_comb begin
      w_we     = 1'b0;
      w_wdata  = '0;
      w_addr_a = '0;
      w_addr_b = '0;
      if (r_state == CLEAR) begin
         w_we     = 1'b1;
         w_addr_a = r_counter;
      end else begin
         if (w_grant[0]) begin
            w_addr_a = req_address[0];
            if (req_write[0]) begin
               w_we    = 1'b1;
               w_wdata = req_write_data[0];
            end
         end
         if (w_grant[1]) begin
            if (req_write[1]) begin
               w_we     = 1'b1;
               w_addr_a = req_address[1];
               w_wdata  = req_write_data[1];
            end else begin
               w_addr_b = req_address[1];
            end
         end
      end
   end

   assign w_port_data = {rf_read_data_b, rf_read_data_a};

   genvar gi;
   generate
      for (gi = 0; gi < C_NUM_REQ; gi++) begin : g_rsp
         logic                      r_valid;
         logic [REGISTER_WIDTH-1:0] r_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
               r_data  <= '0;
            end else begin
               r_valid <= w_grant[gi] & ~req_write[gi];
               if (w_grant[gi] && !req_write[gi]) begin
                  r_data <= w_port_data[gi];
               end
            end
         end

         assign rsp_valid[gi] = r_valid;
         assign rsp_data[gi]  = r_data;
      end
   endgenerate

   assign req_ready       = w_grant;
   assign busy            = (r_state == CLEAR);
   assign clear_done      = r_clear_done;
   assign rf_write_enable = w_we;
   assign rf_write_data   = w_wdata;
   assign rf_address_a    = w_addr_a;
   assign rf_address_b    = w_addr_b;

endmodule
`default_nettype wire

// File: tb/tb_register_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_arbiter
// Brief    : Directed scoreboard bench for register_file_arbiter.
// Revision : 1.0
// ============================================================================
module tb_register_file_arbiter;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int H  = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]         req_valid, req_ready, req_write, rsp_valid;
   logic [1:0][AW-1:0] req_address;
   logic [1:0][DW-1:0] req_write_data, rsp_data;
   logic               clear_start, busy, clear_done, rf_write_enable;
   logic [DW-1:0]      rf_write_data, rf_read_data_a, rf_read_data_b;
   logic [AW-1:0]      rf_address_a, rf_address_b;

   logic [DW-1:0]      rf_mem [H];
   logic [DW-1:0]      q0 [$];
   logic [DW-1:0]      q1 [$];
   int                 vectors     = 0;
   int                 miscompares = 0;

   register_file_arbiter #(
      .ADDRESS_WIDTH   (AW),
      .REGISTER_WIDTH  (DW),
      .REGISTER_HEIGHT (H)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_address     (req_address),
      .req_write_data  (req_write_data),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .clear_start     (clear_start),
      .busy            (busy),
      .clear_done      (clear_done),
      .rf_write_enable (rf_write_enable),
      .rf_write_data   (rf_write_data),
      .rf_address_a    (rf_address_a),
      .rf_address_b    (rf_address_b),
      .rf_read_data_a  (rf_read_data_a),
      .rf_read_data_b  (rf_read_data_b)
   );

   // Register file model: synchronous write, asynchronous dual read.
   always @(posedge clk) begin
      if (rf_write_enable) rf_mem[rf_address_a] <= rf_write_data;
   end
   assign rf_read_data_a = rf_mem[rf_address_a];
   assign rf_read_data_b = rf_mem[rf_address_b];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Response monitor: pops the expected read data whenever a response appears.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid[0]) begin
            if (q0.size() == 0) check("rsp0_unexpected", 32'(rsp_valid[0]), 32'd0);
            else                check("rsp0_data", 32'(rsp_data[0]), 32'(q0.pop_front()));
         end
         if (rsp_valid[1]) begin
            if (q1.size() == 0) check("rsp1_unexpected", 32'(rsp_valid[1]), 32'd0);
            else                check("rsp1_data", 32'(rsp_data[1]), 32'(q1.pop_front()));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      req_valid         = v;
      req_write         = w;
      req_address[0]    = a0;
      req_write_data[0] = d0;
      req_address[1]    = a1;
      req_write_data[1] = d1;
   endtask

   task automatic expect_port(input string name, input logic [1:0] ready, input logic we,
                              input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                              input logic [DW-1:0] wd);
      @(negedge clk);
      check({name, "_ready"}, 32'(req_ready), 32'(ready));
      check({name, "_we"},    32'(rf_write_enable), 32'(we));
      check({name, "_addr_a"}, 32'(rf_address_a), 32'(aa));
      check({name, "_addr_b"}, 32'(rf_address_b), 32'(ab));
      check({name, "_wdata"}, 32'(rf_write_data), 32'(wd));
      check({name, "_busy"},  32'(busy), 32'd0);
   endtask

   // Entered at the start of clear cycle 0; returns at the negedge of cycle H.
   task automatic check_clear(input string tag);
      for (int k = 0; k < H; k++) begin
         @(negedge clk);
         check({tag, "_busy"},  32'(busy), 32'd1);
         check({tag, "_we"},    32'(rf_write_enable), 32'd1);
         check({tag, "_addr"},  32'(rf_address_a), 32'(k));
         check({tag, "_wdata"}, 32'(rf_write_data), 32'd0);
         check({tag, "_ready"}, 32'(req_ready), 32'd0);
         check({tag, "_done"},  32'(clear_done), 32'd0);
         if (k == H - 1) req_valid = 2'b00;
         next_cycle();
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(clear_done), 32'd1);
      check({tag, "_busy_low"},   32'(busy), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},     32'(busy), 32'd1);
      check({tag, "_we"},       32'(rf_write_enable), 32'd1);
      check({tag, "_addr"},     32'(rf_address_a), 32'd0);
      check({tag, "_wdata"},    32'(rf_write_data), 32'd0);
      check({tag, "_done"},     32'(clear_done), 32'd0);
      check({tag, "_rsp_v"},    32'(rsp_valid), 32'd0);
      check({tag, "_rsp_d0"},   32'(rsp_data[0]), 32'd0);
      check({tag, "_rsp_d1"},   32'(rsp_data[1]), 32'd0);
      check({tag, "_ready"},    32'(req_ready), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_start = 1'b0;
      drive(2'b11, 2'b11, 6'd9, 16'hFFFF, 6'd9, 16'hFFFF);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values("rst1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_clear("clr1");
      next_cycle();

      // Both writing continuously: grants alternate starting with requester 0.
      drive(2'b11, 2'b11, 6'd10, 16'h1010, 6'd11, 16'h1111);
      expect_port("alt0", 2'b01, 1'b1, 6'd10, 6'd0, 16'h1010); next_cycle();
      drive(2'b11, 2'b11, 6'd12, 16'h1212, 6'd11, 16'h1111);
      expect_port("alt1", 2'b10, 1'b1, 6'd11, 6'd0, 16'h1111); next_cycle();
      drive(2'b11, 2'b11, 6'd12, 16'h1212, 6'd13, 16'h1313);
      expect_port("alt2", 2'b01, 1'b1, 6'd12, 6'd0, 16'h1212); next_cycle();
      drive(2'b11, 2'b11, 6'd14, 16'h1414, 6'd13, 16'h1313);
      expect_port("alt3", 2'b10, 1'b1, 6'd13, 6'd0, 16'h1313); next_cycle();
      drive(2'b01, 2'b11, 6'd14, 16'h1414, 6'd0, 16'h0000);
      expect_port("alt4", 2'b01, 1'b1, 6'd14, 6'd0, 16'h1414); next_cycle();

      // Preload and simultaneous reads.
      drive(2'b10, 2'b10, 6'd0, 16'h0000, 6'd7, 16'h0007);
      expect_port("pre7", 2'b10, 1'b1, 6'd7, 6'd0, 16'h0007); next_cycle();
      drive(2'b01, 2'b01, 6'd3, 16'h0003, 6'd0, 16'h0000);
      expect_port("pre3", 2'b01, 1'b1, 6'd3, 6'd0, 16'h0003); next_cycle();
      drive(2'b11, 2'b00, 6'd3, 16'h0000, 6'd7, 16'h0000);
      q0.push_back(16'h0003); q1.push_back(16'h0007);
      expect_port("dual", 2'b11, 1'b0, 6'd3, 6'd7, 16'h0000); next_cycle();
      drive(2'b00, 2'b00, 6'd0, 16'h0000, 6'd0, 16'h0000);
      expect_port("idle", 2'b00, 1'b0, 6'd0, 6'd0, 16'h0000); next_cycle();
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd0);
      check("hold_d0", 32'(rsp_data[0]), 32'h0003);
      check("hold_d1", 32'(rsp_data[1]), 32'h0007);
      next_cycle();

      // Write then read on requester 0, single read on port B, mixed read/write.
      drive(2'b01, 2'b01, 6'd5, 16'hBEEF, 6'd0, 16'h0000);
      expect_port("wr5", 2'b01, 1'b1, 6'd5, 6'd0, 16'hBEEF); next_cycle();
      drive(2'b01, 2'b00, 6'd5, 16'h0000, 6'd0, 16'h0000);
      q0.push_back(16'hBEEF);
      expect_port("rd5", 2'b01, 1'b0, 6'd5, 6'd0, 16'h0000); next_cycle();
      drive(2'b10, 2'b00, 6'd0, 16'h0000, 6'd12, 16'h0000);
      q1.push_back(16'h1212);
      expect_port("rdb", 2'b10, 1'b0, 6'd0, 6'd12, 16'h0000); next_cycle();
      drive(2'b11, 2'b10, 6'd14, 16'h0000, 6'd20, 16'h2020);
      q0.push_back(16'h1414);
      expect_port("mix0", 2'b01, 1'b0, 6'd14, 6'd0, 16'h0000); next_cycle();
      drive(2'b10, 2'b10, 6'd0, 16'h0000, 6'd20, 16'h2020);
      expect_port("mix1", 2'b10, 1'b1, 6'd20, 6'd0, 16'h2020); next_cycle();
      drive(2'b11, 2'b00, 6'd20, 16'h0000, 6'd13, 16'h0000);
      q0.push_back(16'h2020); q1.push_back(16'h1313);
      expect_port("dual2", 2'b11, 1'b0, 6'd20, 6'd13, 16'h0000); next_cycle();
      drive(2'b00, 2'b00, 6'd0, 16'h0000, 6'd0, 16'h0000);
      next_cycle();

      // Clear request collides with a write from requester 1.
      drive(2'b10, 2'b10, 6'd0, 16'h0000, 6'd21, 16'hDEAD);
      clear_start = 1'b1;
      expect_port("clrreq", 2'b00, 1'b0, 6'd0, 6'd0, 16'h0000); next_cycle();
      clear_start = 1'b0;
      check_clear("clr2");
      next_cycle();
      drive(2'b11, 2'b00, 6'd5, 16'h0000, 6'd7, 16'h0000);
      q0.push_back(16'h0000); q1.push_back(16'h0000);
      expect_port("pc0", 2'b11, 1'b0, 6'd5, 6'd7, 16'h0000); next_cycle();
      drive(2'b11, 2'b00, 6'd10, 16'h0000, 6'd21, 16'h0000);
      q0.push_back(16'h0000); q1.push_back(16'h0000);
      expect_port("pc1", 2'b11, 1'b0, 6'd10, 6'd21, 16'h0000); next_cycle();
      drive(2'b01, 2'b01, 6'd30, 16'h3030, 6'd0, 16'h0000);
      expect_port("wr30", 2'b01, 1'b1, 6'd30, 6'd0, 16'h3030); next_cycle();
      drive(2'b01, 2'b00, 6'd30, 16'h0000, 6'd0, 16'h0000);
      q0.push_back(16'h3030);
      expect_port("rd30", 2'b01, 1'b0, 6'd30, 6'd0, 16'h0000); next_cycle();
      drive(2'b00, 2'b00, 6'd0, 16'h0000, 6'd0, 16'h0000);
      next_cycle();

      // Reset pulsed in the middle of a clear.
      clear_start = 1'b1;
      expect_port("clr3req", 2'b00, 1'b0, 6'd0, 6'd0, 16'h0000); next_cycle();
      clear_start = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         check("mid_addr", 32'(rf_address_a), 32'(k));
         if (k < 20) next_cycle();
      end
      rst_n = 1'b0;
      #1;
      check_reset_values("rst2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_clear("clr3");
      next_cycle();

      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
